// File: rtl/mem_port_pkg.sv
// Shared definitions for the dcpu memory port: bus widths and sequencer states.
package mem_port_pkg;

    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 8;
    localparam int REGSEL_W = 3;
    localparam int CTR_W    = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_FIN    = 2'd2,
        ST_FAULT  = 2'd3
    } state_t;

endpackage

// File: rtl/mem_port_if.sv
// External memory bus: req/ack handshake with address, write data and read data.
interface mem_port_if;
    import mem_port_pkg::*;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdat;
    logic [DATA_W-1:0] mem_rdat;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdat,
        input  mem_rdat, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdat,
        output mem_rdat, mem_ack
    );

endinterface

// File: rtl/mem_wait_ctr.sv
// Saturating wait-cycle counter; o_last flags that the next increment reaches a nonzero limit.
module mem_wait_ctr
    import mem_port_pkg::*;
(
    input  logic             clk,
    input  logic             i_reset,
    input  logic             i_clr,
    input  logic             i_inc,
    input  logic [CTR_W-1:0] i_limit,
    output logic             o_last
);

    logic [CTR_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (i_reset || i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + CTR_W'(1);
        end
    end

    // A zero limit disables the timeout entirely.
    assign o_last = (i_limit != '0) && (r_count == (i_limit - CTR_W'(1)));

endmodule

// File: rtl/mem_port.sv
// Memory access sequencer: latches one request, runs req/ack with memory, then
// hands read data to the register file or aborts on timeout.
module mem_port
    import mem_port_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic                i_we,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic [DATA_W-1:0]   i_wdat,
    input  logic [REGSEL_W-1:0] i_reg_sel,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_err,
    output logic                o_load,
    output logic [REGSEL_W-1:0] o_reg_sel,
    output logic [DATA_W-1:0]   o_dat,
    mem_port_if.master          io_mem
);

    localparam logic [CTR_W-1:0] LIMIT = CTR_W'(TIMEOUT_CYCLES);

    state_t                r_state;
    state_t                w_next;
    logic                  w_ctr_clr;
    logic                  w_ctr_inc;
    logic                  w_ctr_last;
    logic                  r_we;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_wdat;
    logic [REGSEL_W-1:0]   r_reg_sel;
    logic [DATA_W-1:0]     r_dat;

    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_state   <= ST_IDLE;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdat    <= '0;
            r_reg_sel <= '0;
            r_dat     <= '0;
        end else begin
            r_state <= w_next;
            if ((r_state == ST_IDLE) && i_start) begin
                r_we      <= i_we;
                r_addr    <= i_addr;
                r_wdat    <= i_wdat;
                r_reg_sel <= i_reg_sel;
            end
            if ((r_state == ST_ACCESS) && io_mem.mem_ack && !r_we) begin
                r_dat <= io_mem.mem_rdat;
            end
        end
    end

    // Ack takes priority over the limit so a late ack still completes normally.
    always_comb begin
        w_next    = r_state;
        w_ctr_clr = 1'b0;
        w_ctr_inc = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_ctr_clr = 1'b1;
                    w_next    = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (io_mem.mem_ack) begin
                    w_next = ST_FIN;
                end else begin
                    w_ctr_inc = 1'b1;
                    if (w_ctr_last) begin
                        w_next = ST_FAULT;
                    end
                end
            end
            ST_FIN:   w_next = ST_IDLE;
            ST_FAULT: w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    mem_wait_ctr u_wait_ctr (
        .clk     (clk),
        .i_reset (i_reset),
        .i_clr   (w_ctr_clr),
        .i_inc   (w_ctr_inc),
        .i_limit (LIMIT),
        .o_last  (w_ctr_last)
    );

    assign o_busy    = (r_state != ST_IDLE);
    assign o_done    = (r_state == ST_FIN);
    assign o_err     = (r_state == ST_FAULT);
    assign o_load    = (r_state == ST_FIN) && !r_we;
    assign o_reg_sel = r_reg_sel;
    assign o_dat     = r_dat;

    assign io_mem.mem_req  = (r_state == ST_ACCESS);
    assign io_mem.mem_we   = r_we;
    assign io_mem.mem_addr = r_addr;
    assign io_mem.mem_wdat = r_wdat;

endmodule

// File: doc/mem_port.md
# mem_port

Memory access sequencer between the dcpu control unit, the 8-bit register file and the external memory bus. On a start pulse it latches a 16-bit address (a register-pair address from the register file), runs a req/ack handshake with memory, and finishes in one of two ways. For a read, it presents the returned byte with a one-cycle load strobe and destination select, which feed the register file's `i_dat`, `i_load` and `i_reg_sel` inputs. For a write, it drives a register byte onto the bus. A wait-cycle counter turns a missing ack into an error pulse so the CPU never hangs.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16, ACCESS cycles without ack before abort; legal range 0..255; 0 disables the timeout.

Ports:
- clk  in  1  clock; all logic on its rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_start  in  1  start one access; sampled only in IDLE.
- i_we  in  1  1 = write, 0 = read; latched with i_start.
- i_addr  in  16  access address (register-pair output of the register file).
- i_wdat  in  8  write data (register-file ALU-left output).
- i_reg_sel  in  3  destination register for a read.
- o_busy  out  1  high in every non-IDLE state.
- o_done  out  1  one-cycle pulse when an access completes successfully.
- o_err  out  1  one-cycle pulse when an access is aborted by timeout.
- o_load  out  1  one-cycle load strobe to the register file; reads only.
- o_reg_sel  out  3  latched destination register select.
- o_dat  out  8  captured read data.
- o_mem_req  out  1  bus request.
- o_mem_we  out  1  bus write enable; latched copy of i_we.
- o_mem_addr  out  16  latched bus address.
- o_mem_dat  out  8  latched bus write data.
- i_mem_dat  in  8  bus read data; valid in the cycle i_mem_ack is high.
- i_mem_ack  in  1  bus acknowledge.

## Operation
- The module has four states: IDLE, ACCESS, FIN and FAULT.
- **IDLE**
  - When i_start=1, latch i_we, i_addr, i_wdat and i_reg_sel into o_mem_we, o_mem_addr, o_mem_dat and o_reg_sel.
  - Clear the wait counter and go to ACCESS.
- **ACCESS**
  - o_mem_req=1.
  - If i_mem_ack=1:
    - for a read, capture i_mem_dat into o_dat;
    - go to FIN.
  - Otherwise, increment the wait counter. When TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES, go to FAULT.
- **FIN**
  - o_done=1.
  - o_load equals the latched read flag (not o_mem_we).
  - o_mem_req=0.
  - Go to IDLE.
- **FAULT**
  - o_err=1, o_mem_req=0 and o_load=0; o_dat keeps its previous value.
  - Go to IDLE.
- **Stability rules**
  - Latched bus outputs and o_reg_sel stay stable from ACCESS entry until the next accepted start.
  - o_dat changes only on an acked read.
- **Ignored and tie-break conditions**
  - i_start outside IDLE is ignored and not queued.
  - i_mem_ack outside ACCESS is ignored.
  - If ack arrives in the same cycle the counter would reach the limit, ack wins and the access completes normally.
- **Counter width**: the wait counter is 8 bits and saturates; it never wraps.

## Timing
- **Reset values**: every output is 0 after reset (o_busy, o_done, o_err, o_load, o_reg_sel, o_dat, o_mem_req, o_mem_we, o_mem_addr, o_mem_dat). The state is IDLE and the counter is 0.
- **Reset mid-access**: reset in any state forces IDLE at the next edge. o_mem_req drops, and no o_done, o_err or o_load is issued.
- **Zero-wait access**, with i_start in cycle 0:
  - o_mem_req is high in cycle 1;
  - an ack in cycle 1 gives o_done/o_load in cycle 2;
  - the module is back in IDLE in cycle 3.
- **Waited access**: each cycle without ack adds one cycle to that sequence.
- **Minimum spacing**: accepted starts are at least 3 cycles apart.
- **Timeout**: o_mem_req stays high for exactly TIMEOUT_CYCLES cycles, then o_err is high for one cycle.
- **Register-file hand-off**: o_dat, o_reg_sel and o_load are registered and valid together for exactly one cycle. The register file writes at the end of FIN.

## Structure
- A shared dcpu package holds:
  - the state encoding (localparams ST_IDLE=2'd0, ST_ACCESS=2'd1, ST_FIN=2'd2, ST_FAULT=2'd3);
  - the bus widths (ADDR_W=16, DATA_W=8, REGSEL_W=3).
- One sub-module is natural: mem_wait_ctr, an 8-bit clear/increment saturating counter with a compare-to-limit output and a disable-on-zero limit.

## Test plan
- **Read, zero wait**: start with i_we=0, i_addr=16'h1234, i_reg_sel=3; ack in cycle 1 with i_mem_dat=8'hA5. Required: o_mem_addr=16'h1234 in cycle 1; in cycle 2 o_load=1, o_done=1, o_dat=8'hA5, o_reg_sel=3.
- **Write, three waits**: start with i_we=1, i_wdat=8'h3C; ack on the 4th ACCESS cycle. Required: o_mem_req high for exactly 4 cycles with o_mem_dat=8'h3C; then o_done=1 and o_load=0.
- **Timeout**: TIMEOUT_CYCLES=4, no ack. Required: o_mem_req high for 4 cycles, then o_err=1 for 1 cycle; o_load and o_done stay 0 and o_dat is unchanged.
- **Ack/limit tie and stray ack**: TIMEOUT_CYCLES=4 with ack in the 4th ACCESS cycle. Required: o_done, no o_err. Separately, an ack in IDLE or FIN is ignored, and i_start pulses in ACCESS or FIN are not accepted.
- **Reset mid-access**: assert i_reset in the 2nd ACCESS cycle. Required: all outputs are 0 next cycle, and a following ack is ignored.
- **Back-to-back reads**: start pulses in cycles 0 and 3 with TIMEOUT_CYCLES=0. Required: both complete with correct o_dat, and their o_load pulses fall in cycles 2 and 5.
